// File: rtl/aes_pkg.sv
// Shared AES types and byte-substitution tables for the encrypt and decrypt paths.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    // Byte-addressable view of a state: element 0 is the most significant byte.
    typedef logic [0:15][7:0] aes_state_bytes_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sub_state_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box lookup; purely combinational.
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t value,
    output aes_byte_t result
);

    // Constant table lookup; synthesises to a 256x8 ROM / logic cone.
    assign result = INV_SBOX[value];

endmodule

// File: rtl/inv_s_sub.sv
// AES InvSubBytes stage: substitutes LANES bytes per clock through a shared
// bank of inverse S-box units and returns the full state with a one-cycle strobe.
module inv_s_sub
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         o_en,
    output logic         busy
);

    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject lane counts that do not divide the state into equal groups.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_s_sub: LANES must be 1, 2, 4, 8 or 16");
    end

    sub_state_t       state;
    aes_state_bytes_t work_reg;
    aes_state_bytes_t next_work;
    logic [CNT_W-1:0] cnt;

    logic [3:0] lane_idx [LANES];
    aes_byte_t  lane_out [LANES];

    // One lookup unit per lane; lane l handles byte cnt*LANES + l of the state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(cnt) * LANES + l);

        inv_sbox u_inv_sbox (
            .value  (work_reg[lane_idx[l]]),
            .result (lane_out[l])
        );
    end

    // Merge the current lane group's substituted bytes into the working state.
    always_comb begin
        // NOTE: default assignment first so every path drives next_work; no latch can be inferred.
        next_work = work_reg;
        for (int l = 0; l < LANES; l++) begin
            next_work[lane_idx[l]] = lane_out[l];
        end
    end

    // Control FSM, lane-group counter, working register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            work_reg <= '0;
            cnt      <= '0;
            data_out <= '0;
            o_en     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            o_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        work_reg <= data_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg <= next_work;
                    if (cnt == CNT_W'(N - 1)) begin
                        // Final group: publish the whole state at once; cnt holds until the next capture.
                        data_out <= next_work;
                        o_en     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_s_sub.sv
// Scoreboard bench for inv_s_sub at LANES = 1, 4 and 16.
module tb_inv_s_sub;
    import aes_pkg::*;

    localparam int NDUT   = 3;
    localparam int LV[3]  = '{1, 4, 16};
    localparam int NV[3]  = '{16, 4, 1};

    localparam aes_state_t VEC1_IN  = 128'h090862bf6f28e3042c747feeda4a6a47;
    localparam aes_state_t VEC1_OUT = 128'h40bfabf406ee4d3042ca6b997a5c5816;
    localparam aes_state_t ALL52    = {16{8'h52}};
    localparam aes_state_t ALL63    = {16{8'h63}};
    localparam aes_state_t ALLFF    = {16{8'hff}};

    typedef struct {
        int         idx;
        aes_state_t data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_en     [NDUT];
    aes_state_t data_in  [NDUT];
    aes_state_t data_out [NDUT];
    logic       o_en     [NDUT];
    logic       busy     [NDUT];

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_s_sub #(.LANES(LV[g])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_en     (i_en[g]),
            .data_in  (data_in[g]),
            .data_out (data_out[g]),
            .o_en     (o_en[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic aes_state_t fwd_sub(input aes_state_t x);
        aes_state_t r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = SBOX[x[127-8*k -: 8]];
        return r;
    endfunction

    // Monitor: every o_en must match the oldest pending expectation for that instance.
    always @(negedge clk) begin
        int k;
        for (int g = 0; g < NDUT; g++) begin
            if (!rst && o_en[g]) begin
                k = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].idx == g) begin
                        k = j;
                        break;
                    end
                end
                if (k < 0) begin
                    check($sformatf("unexpected o_en L%0d", LV[g]), 128'(o_en[g]), 128'(0));
                end else begin
                    check($sformatf("data_out L%0d", LV[g]), data_out[g], sb[k].data);
                    check($sformatf("latency cycle L%0d", LV[g]), 128'(cyc), 128'(sb[k].due));
                    sb.delete(k);
                end
            end
        end
    end

    // Drive one input for one cycle starting at the current (negedge) time.
    task automatic send(input int g, input aes_state_t d, input aes_state_t exp, input bit accept);
        i_en[g]    = 1'b1;
        data_in[g] = d;
        if (accept) sb.push_back('{g, exp, cyc + 1 + NV[g]});
        @(negedge clk);
        i_en[g] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aes_state_t x;
        int         n;
        for (int g = 0; g < NDUT; g++) begin
            i_en[g]    = 1'b0;
            data_in[g] = '0;
        end

        // Reset values on every instance.
        #2;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset data_out L%0d", LV[g]), data_out[g], 128'(0));
            check($sformatf("reset o_en L%0d", LV[g]), 128'(o_en[g]), 128'(0));
            check($sformatf("reset busy L%0d", LV[g]), 128'(busy[g]), 128'(0));
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reference vector through every lane width, then the constant patterns.
        for (int g = 0; g < NDUT; g++) begin
            send(g, VEC1_IN, VEC1_OUT, 1'b1);
            check($sformatf("busy after capture L%0d", LV[g]), 128'(busy[g]), 128'(1));
            drain();
            check($sformatf("busy after done L%0d", LV[g]), 128'(busy[g]), 128'(0));
            send(g, '0, ALL52, 1'b1);
            drain();
            send(g, ALL63, '0, 1'b1);
            drain();
        end

        // i_en while busy is ignored; only one o_en follows.
        send(1, VEC1_IN, VEC1_OUT, 1'b1);
        send(1, ALLFF, '0, 1'b0);
        check("busy during ignored i_en", 128'(busy[1]), 128'(1));
        drain();
        repeat (8) @(negedge clk);
        check("data_out held", data_out[1], VEC1_OUT);

        // i_en in the o_en cycle is accepted; second o_en is N+1 cycles later.
        send(1, ALL63, '0, 1'b1);
        n = 0;
        while (!o_en[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first o_en seen", 128'(o_en[1]), 128'(1));
        send(1, VEC1_IN, VEC1_OUT, 1'b1);
        drain();

        // Reset at edge 2 of processing discards the in-flight state.
        send(1, VEC1_IN, VEC1_OUT, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("mid reset data_out", data_out[1], 128'(0));
        check("mid reset o_en", 128'(o_en[1]), 128'(0));
        check("mid reset busy", 128'(busy[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no o_en after reset", data_out[1], 128'(0));
        send(1, ALL63, '0, 1'b1);
        drain();

        // Round trip: forward-substituted random states must come back unchanged.
        for (int g = 0; g < NDUT; g++) begin
            for (int t = 0; t < 4; t++) begin
                x = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(g, fwd_sub(x), x, 1'b1);
                drain();
            end
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
